// File: rtl/mux_arbiter.sv
// ---------------------------------------------------------------------------
// mux_arbiter
//
// Round-robin, packet-locked arbiter that shares one mux datapath among
// N = 2**SELECT_LINES requesters. A requester that wins keeps the grant
// until it completes a packet (a transfer carrying in_last). Ownership then
// passes to the next requester in rotation, with no idle cycle in between.
// grant, select and busy are registered, so there is no combinational path
// from req to grant. select is meant to drive the select lines of a mux
// instance that has the same SELECT_LINES.
//
// Parameters
//   SELECT_LINES    width of select; N = 2**SELECT_LINES requesters
//   TIMEOUT_CYCLES  idle-owner cycles before the grant is revoked (1..65535),
//                   used only when MUX_ARBITER_TIMEOUT_EN is defined
//
// Optional feature macro
//   MUX_ARBITER_TIMEOUT_EN  when defined, an owner that holds the grant with
//                           req low for TIMEOUT_CYCLES cycles loses the
//                           grant, and timeout pulses for one cycle. When it
//                           is not defined, timeout is tied low and a grant
//                           is held until in_last.
//
// Ports
//   clk        in   1             rising-edge clock
//   rst_n      in   1             asynchronous active-low reset
//   req        in   N             per-requester valid
//   in_last    in   N             per-requester end-of-packet (qualified by req)
//   in_ready   out  N             per-requester accept = grant & {N{out_ready}}
//   out_ready  in   1             downstream accept
//   out_valid  out  1             busy & req[select]
//   out_last   out  1             busy & req[select] & in_last[select]
//   grant      out  N             registered one-hot owner, zero when idle
//   select     out  SELECT_LINES  registered binary owner index
//   busy       out  1             registered, high while a grant is held
//   timeout    out  1             registered one-cycle pulse on revocation
// ---------------------------------------------------------------------------
module mux_arbiter #(
   parameter int SELECT_LINES   = 2,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [(2**SELECT_LINES)-1:0]   req,
   input  logic [(2**SELECT_LINES)-1:0]   in_last,
   output logic [(2**SELECT_LINES)-1:0]   in_ready,
   input  logic                           out_ready,
   output logic                           out_valid,
   output logic                           out_last,
   output logic [(2**SELECT_LINES)-1:0]   grant,
   output logic [SELECT_LINES-1:0]        select,
   output logic                           busy,
   output logic                           timeout
);

   localparam int N = 2**SELECT_LINES;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // Round-robin search. The result is {found, index}. The search starts at
   // base+1 and wraps modulo N; offset N lands back on base, so base itself
   // is the last candidate. The loop runs from the farthest offset to the
   // nearest, so the nearest asserted request overwrites the others and wins.
   function automatic logic [SELECT_LINES:0] rr_pick(
      input logic [N-1:0]            r,
      input logic [SELECT_LINES-1:0] base
   );
      logic [SELECT_LINES:0]   res;
      logic [SELECT_LINES-1:0] idx;
      res = '0;
      for (int k = N; k >= 1; k--) begin
         // Truncating to SELECT_LINES bits gives the modulo-N wrap, since N
         // is a power of two.
         idx = base + SELECT_LINES'(k);
         if (r[idx]) begin
            res = {1'b1, idx};
         end
      end
      return res;
   endfunction

   // Converts a binary index into a one-hot grant vector.
   function automatic logic [N-1:0] to_onehot(input logic [SELECT_LINES-1:0] idx);
      logic [N-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   state_t                  state_r;
   logic [N-1:0]            grant_r;
   logic [SELECT_LINES-1:0] select_r;
   logic                    busy_r;
   logic [SELECT_LINES-1:0] last_winner_r;

   logic [SELECT_LINES:0]   idle_pick_s;
   logic [SELECT_LINES:0]   busy_pick_s;
   logic                    owner_req_s;
   logic                    last_xfer_s;

`ifdef MUX_ARBITER_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0]             idle_cnt_r;
   logic                    timeout_r;
   logic                    expire_s;
`endif

   // In IDLE the search starts after the previous winner. At a packet
   // boundary it starts after the current owner, and the owner is still
   // eligible as the last candidate.
   assign idle_pick_s = rr_pick(req, last_winner_r);
   assign busy_pick_s = rr_pick(req, select_r);

   assign owner_req_s = req[select_r];
   assign last_xfer_s = busy_r & owner_req_s & out_ready & in_last[select_r];

`ifdef MUX_ARBITER_TIMEOUT_EN
   // This is the cycle that brings the idle count to TIMEOUT_CYCLES.
   assign expire_s = busy_r & ~owner_req_s & (idle_cnt_r == TIMEOUT_LIMIT);
`endif

   // Arbitration FSM. It owns grant/select/busy, the rotation pointer and
   // the optional idle-owner timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= ST_IDLE;
         grant_r       <= '0;
         select_r      <= '0;
         busy_r        <= 1'b0;
         last_winner_r <= SELECT_LINES'(N - 1);
`ifdef MUX_ARBITER_TIMEOUT_EN
         idle_cnt_r    <= 16'd0;
         timeout_r     <= 1'b0;
`endif
      end else begin
`ifdef MUX_ARBITER_TIMEOUT_EN
         timeout_r <= 1'b0;
`endif
         case (state_r)
            ST_IDLE: begin
`ifdef MUX_ARBITER_TIMEOUT_EN
               idle_cnt_r <= 16'd0;
`endif
               if (idle_pick_s[SELECT_LINES]) begin
                  grant_r       <= to_onehot(idle_pick_s[SELECT_LINES-1:0]);
                  select_r      <= idle_pick_s[SELECT_LINES-1:0];
                  last_winner_r <= idle_pick_s[SELECT_LINES-1:0];
                  busy_r        <= 1'b1;
                  state_r       <= ST_BUSY;
               end else begin
                  // select keeps its last value while idle.
                  grant_r <= '0;
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end
            end

            ST_BUSY: begin
`ifdef MUX_ARBITER_TIMEOUT_EN
               if (expire_s) begin
                  // Revocation does not re-arbitrate in the same cycle.
                  // last_winner already points at the revoked owner, so
                  // that owner has the lowest priority next time.
                  grant_r    <= '0;
                  busy_r     <= 1'b0;
                  state_r    <= ST_IDLE;
                  timeout_r  <= 1'b1;
                  idle_cnt_r <= 16'd0;
               end else
`endif
               if (last_xfer_s) begin
                  if (busy_pick_s[SELECT_LINES]) begin
                     grant_r       <= to_onehot(busy_pick_s[SELECT_LINES-1:0]);
                     select_r      <= busy_pick_s[SELECT_LINES-1:0];
                     last_winner_r <= busy_pick_s[SELECT_LINES-1:0];
                     busy_r        <= 1'b1;
                     state_r       <= ST_BUSY;
                  end else begin
                     grant_r <= '0;
                     busy_r  <= 1'b0;
                     state_r <= ST_IDLE;
                  end
`ifdef MUX_ARBITER_TIMEOUT_EN
                  idle_cnt_r <= 16'd0;
`endif
               end else begin
                  // Mid-packet or stalled: the grant is held, and requests
                  // from other requesters are not looked at.
                  grant_r <= grant_r;
                  busy_r  <= 1'b1;
                  state_r <= ST_BUSY;
`ifdef MUX_ARBITER_TIMEOUT_EN
                  if (owner_req_s) begin
                     idle_cnt_r <= 16'd0;
                  end else begin
                     idle_cnt_r <= idle_cnt_r + 16'd1;
                  end
`endif
               end
            end

            default: begin
               state_r <= ST_IDLE;
               grant_r <= '0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign grant     = grant_r;
   assign select    = select_r;
   assign busy      = busy_r;
   assign in_ready  = grant_r & {N{out_ready}};
   assign out_valid = busy_r & owner_req_s;
   assign out_last  = busy_r & owner_req_s & in_last[select_r];

`ifdef MUX_ARBITER_TIMEOUT_EN
   assign timeout = timeout_r;
`else
   assign timeout = 1'b0;
`endif

endmodule
